// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM controller request interface between the
// pipeline MEM stage (port P, fixed priority) and a DMA/loader master (port D).
// Each grant is held until the controller reports completion. A saturating
// counter bounds how many P grants can be issued while D is waiting.
module sram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        p_read_en,
    input  logic        p_write_en,
    input  logic [31:0] p_address,
    input  logic [31:0] p_write_data,
    output logic [31:0] p_read_data,
    output logic        p_ready,

    input  logic        d_read_en,
    input  logic        d_write_en,
    input  logic [31:0] d_address,
    input  logic [31:0] d_write_data,
    output logic [31:0] d_read_data,
    output logic        d_ready,

    output logic        mem_read_en,
    output logic        mem_write_en,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    input  logic        mem_ready,

    output logic        grant_d
);

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_P = 2'd1,
        SERVE_D = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          grant_d_q, grant_d_d;

    logic p_req, d_req;
    logic p_is_rd, d_is_rd;
    logic starve_full;
    logic complete;

    // Request decode: write wins when both enables are set.
    always_comb begin
        p_req       = p_read_en | p_write_en;
        d_req       = d_read_en | d_write_en;
        p_is_rd     = p_read_en & ~p_write_en;
        d_is_rd     = d_read_en & ~d_write_en;
        starve_full = (starve_q == LIMIT);
        // A reset cycle aborts the access, so it never shows a completion.
        complete    = mem_ready & ~rst;
    end

    // Next-state, starvation counter and combinational port muxing.
    always_comb begin
        state_d        = state_q;
        starve_d       = starve_q;
        mem_read_en    = 1'b0;
        mem_write_en   = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        p_ready        = ~p_req;
        d_ready        = ~d_req;
        p_read_data    = '0;
        d_read_data    = '0;

        unique case (state_q)
            IDLE: begin
                if (p_req && !(d_req && starve_full)) begin
                    state_d = SERVE_P;
                    if (d_req && (starve_q < LIMIT)) begin
                        starve_d = starve_q + CW'(1);
                    end
                end else if (d_req) begin
                    state_d  = SERVE_D;
                    starve_d = '0;
                end
            end

            SERVE_P: begin
                mem_read_en    = p_is_rd;
                mem_write_en   = p_write_en;
                mem_address    = p_address;
                mem_write_data = p_write_data;
                if (complete) begin
                    p_ready     = 1'b1;
                    p_read_data = p_is_rd ? mem_read_data : '0;
                    state_d     = IDLE;
                end
            end

            SERVE_D: begin
                mem_read_en    = d_is_rd;
                mem_write_en   = d_write_en;
                mem_address    = d_address;
                mem_write_data = d_write_data;
                if (complete) begin
                    d_ready     = 1'b1;
                    d_read_data = d_is_rd ? mem_read_data : '0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        grant_d_d = (state_d == SERVE_D);
    end

    // State, starvation counter and registered grant status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            grant_d_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            grant_d_q <= grant_d_d;
        end
    end

    assign grant_d = grant_d_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios followed by
// randomized traffic against a transaction-level reference model.
module tb_sram_arbiter;

    localparam int LIMIT = 2;

    logic        clk;
    logic        rst;
    logic        p_read_en, p_write_en;
    logic [31:0] p_address, p_write_data, p_read_data;
    logic        p_ready;
    logic        d_read_en, d_write_en;
    logic [31:0] d_address, d_write_data, d_read_data;
    logic        d_ready;
    logic        mem_read_en, mem_write_en;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_ready;
    logic        grant_d;

    // Controller model: busy for lat enabled cycles, ready in the last one.
    logic [2:0]  lat;
    logic [2:0]  ctl_cnt;
    logic [31:0] ctl_rdata;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the memory (0 none, 1 P, 2 D) and how many
    // P grants have been issued while D waited.
    int own;
    int starve;
    logic last_p_done, last_d_done;

    // Observed DUT outputs at the last sample point.
    logic        s_ren, s_wen, s_pready, s_dready, s_grant;
    logic [31:0] s_addr, s_wd, s_prd, s_drd;

    sram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .p_read_en(p_read_en), .p_write_en(p_write_en),
        .p_address(p_address), .p_write_data(p_write_data),
        .p_read_data(p_read_data), .p_ready(p_ready),
        .d_read_en(d_read_en), .d_write_en(d_write_en),
        .d_address(d_address), .d_write_data(d_write_data),
        .d_read_data(d_read_data), .d_ready(d_ready),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .mem_ready(mem_ready),
        .grant_d(grant_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_ready     = rst | ~(mem_read_en | mem_write_en) | (ctl_cnt == lat - 3'd1);
    assign mem_read_data = ctl_rdata;

    always @(posedge clk) begin
        if (rst)                                           ctl_cnt <= 3'd0;
        else if ((mem_read_en | mem_write_en) && !mem_ready) ctl_cnt <= ctl_cnt + 3'd1;
        else                                               ctl_cnt <= 3'd0;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: sample and check at negedge, advance the model,
    // then return just after the next rising edge ready for new inputs.
    task automatic tick();
        logic        pr, dr, e_ren, e_wen, e_mr, pd, dd;
        logic [31:0] e_addr, e_wd, e_prd, e_drd;
        int          own_n, starve_n;
        @(negedge clk);
        s_ren = mem_read_en;  s_wen = mem_write_en;
        s_addr = mem_address; s_wd = mem_write_data;
        s_pready = p_ready;   s_dready = d_ready;
        s_prd = p_read_data;  s_drd = d_read_data;
        s_grant = grant_d;

        pr = p_read_en | p_write_en;
        dr = d_read_en | d_write_en;
        e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_wd = '0;
        if (own == 1) begin
            e_ren = p_read_en & ~p_write_en; e_wen = p_write_en;
            e_addr = p_address; e_wd = p_write_data;
        end else if (own == 2) begin
            e_ren = d_read_en & ~d_write_en; e_wen = d_write_en;
            e_addr = d_address; e_wd = d_write_data;
        end
        e_mr  = rst | ~(e_ren | e_wen) | (ctl_cnt == lat - 3'd1);
        pd    = (own == 1) && e_mr && !rst;
        dd    = (own == 2) && e_mr && !rst;
        e_prd = (pd && p_read_en && !p_write_en) ? ctl_rdata : 32'h0;
        e_drd = (dd && d_read_en && !d_write_en) ? ctl_rdata : 32'h0;

        check_eq("mem_read_en",    s_ren,    e_ren);
        check_eq("mem_write_en",   s_wen,    e_wen);
        check_eq("mem_address",    s_addr,   e_addr);
        check_eq("mem_write_data", s_wd,     e_wd);
        check_eq("p_ready",        s_pready, !pr || pd);
        check_eq("d_ready",        s_dready, !dr || dd);
        check_eq("p_read_data",    s_prd,    e_prd);
        check_eq("d_read_data",    s_drd,    e_drd);
        check_eq("grant_d",        s_grant,  own == 2);
        last_p_done = pd;
        last_d_done = dd;

        own_n = own; starve_n = starve;
        if (rst) begin
            own_n = 0; starve_n = 0;
        end else if (own == 0) begin
            if (pr && dr) begin
                if (starve == LIMIT) begin own_n = 2; starve_n = 0; end
                else begin own_n = 1; starve_n = (starve + 1 > LIMIT) ? LIMIT : starve + 1; end
            end else if (pr) begin
                own_n = 1;
            end else if (dr) begin
                own_n = 2; starve_n = 0;
            end
        end else if (own == 1 && pd) begin
            own_n = 0;
        end else if (own == 2 && dd) begin
            own_n = 0;
        end
        @(posedge clk);
        #1;
        own = own_n;
        starve = starve_n;
    endtask

    task automatic new_req(output logic rd, output logic wr, output logic [31:0] a, output logic [31:0] w);
        int k;
        k  = $urandom_range(0, 2);
        rd = (k != 1);
        wr = (k != 0);
        a  = $urandom;
        w  = $urandom;
    endtask

    initial begin
        int  n;
        int  got_order[6];
        int  exp_order[6];
        bit  done;

        rst = 1'b1;
        p_read_en = 0; p_write_en = 0; p_address = '0; p_write_data = '0;
        d_read_en = 0; d_write_en = 0; d_address = '0; d_write_data = '0;
        lat = 3'd4; ctl_rdata = 32'h0;
        own = 0; starve = 0; last_p_done = 0; last_d_done = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset values.
        @(negedge clk);
        check_eq("rst_p_ready", p_ready, 1);
        check_eq("rst_d_ready", d_ready, 1);
        check_eq("rst_grant_d", grant_d, 0);
        check_eq("rst_mem_en",  {mem_read_en, mem_write_en}, 0);
        check_eq("rst_mem_addr", mem_address, 0);
        check_eq("rst_rdata",   p_read_data | d_read_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // P read of 0x400, 4-cycle latency; request held a second time to see IDLE.
        lat = 3'd4; ctl_rdata = 32'hDEADBEEF;
        p_read_en = 1; p_address = 32'h400;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i <= 5) begin
                check_eq("t1_mem_read_en", s_ren, (i >= 1 && i <= 4));
                check_eq("t1_p_ready", s_pready, i == 4);
            end
            if (i == 4) check_eq("t1_p_read_data", s_prd, 32'hDEADBEEF);
        end
        p_read_en = 0;
        tick();

        // D write 0x12345678 to 0x800 with P idle.
        lat = 3'd3;
        d_write_en = 1; d_address = 32'h800; d_write_data = 32'h12345678;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (s_dready) n++;
            check_eq("t2_p_ready", s_pready, 1);
            if (i >= 1) begin
                check_eq("t2_grant_d",  s_grant, 1);
                check_eq("t2_mem_addr", s_addr,  32'h800);
                check_eq("t2_mem_wd",   s_wd,    32'h12345678);
            end
        end
        check_eq("t2_d_ready_pulses", n, 1);
        d_write_en = 0;
        tick();
        check_eq("t2_grant_after", s_grant, 0);

        // Both ports continuously requesting: P, P, D, P, P, D.
        lat = 3'd2;
        p_read_en = 1; p_address = 32'h10;
        d_read_en = 1; d_address = 32'h20;
        exp_order = '{1, 1, 2, 1, 1, 2};
        n = 0;
        for (int i = 0; i < 200 && n < 6; i++) begin
            tick();
            if (s_pready && n < 6) begin got_order[n] = 1; n++; end
            if (s_dready && n < 6) begin got_order[n] = 2; n++; end
        end
        for (int i = n; i < 6; i++) got_order[i] = 0;
        for (int i = 0; i < 6; i++) check_eq("t3_grant_order", got_order[i], exp_order[i]);
        p_read_en = 0; d_read_en = 0;
        while (own != 0) tick();
        tick();

        // D arrives during SERVE_P and waits its turn.
        lat = 3'd4;
        p_read_en = 1; p_address = 32'h444;
        tick();
        tick();
        d_read_en = 1; d_address = 32'h900;
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            tick();
            check_eq("t4_d_wait_ready", s_dready, 0);
            done = s_pready;
        end
        check_eq("t4_p_completed", done, 1);
        p_read_en = 0;
        tick();
        check_eq("t4_idle_grant", s_grant, 0);
        check_eq("t4_idle_ren",   s_ren,   0);
        tick();
        check_eq("t4_serve_d_grant", s_grant, 1);
        check_eq("t4_serve_d_addr",  s_addr,  32'h900);
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            tick();
            done = s_dready;
        end
        check_eq("t4_d_completed", done, 1);
        d_read_en = 0;
        tick();

        // Reset in the 2nd cycle of a D access aborts it.
        lat = 3'd4;
        d_write_en = 1; d_address = 32'hC00; d_write_data = 32'hAAAA5555;
        tick();
        check_eq("t5_d_ready_c0", s_dready, 0);
        tick();
        check_eq("t5_d_ready_c1", s_dready, 0);
        rst = 1;
        tick();
        check_eq("t5_d_ready_rst", s_dready, 0);
        rst = 0;
        d_write_en = 0;
        tick();
        check_eq("t5_grant_d", s_grant, 0);
        check_eq("t5_mem_en",  {s_ren, s_wen}, 0);
        check_eq("t5_mem_addr", s_addr, 0);
        check_eq("t5_readies", {s_pready, s_dready}, 2'b11);
        lat = 3'd2; ctl_rdata = 32'h0BADF00D;
        p_read_en = 1; p_address = 32'h404;
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            tick();
            done = s_pready;
            if (done) check_eq("t5_p_rdata", s_prd, 32'h0BADF00D);
        end
        check_eq("t5_p_completed", done, 1);
        p_read_en = 0;
        tick();

        // Both enables set: treated as a write, no read data.
        lat = 3'd3; ctl_rdata = 32'hCAFEF00D;
        p_read_en = 1; p_write_en = 1; p_address = 32'h500; p_write_data = 32'h55;
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            tick();
            if (i >= 1) check_eq("t6_mem_en", {s_ren, s_wen}, 2'b01);
            done = s_pready;
            if (done) check_eq("t6_p_rdata", s_prd, 0);
        end
        check_eq("t6_p_completed", done, 1);
        p_read_en = 0; p_write_en = 0;
        tick();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            ctl_rdata = $urandom;
            if (own == 0) lat = 3'($urandom_range(1, 4));
            rst = ($urandom_range(0, 149) == 0);
            if (!(p_read_en | p_write_en) || last_p_done) begin
                if ($urandom_range(0, 1) == 1) new_req(p_read_en, p_write_en, p_address, p_write_data);
                else begin p_read_en = 0; p_write_en = 0; end
            end
            if (!(d_read_en | d_write_en) || last_d_done) begin
                if ($urandom_range(0, 1) == 1) new_req(d_read_en, d_write_en, d_address, d_write_data);
                else begin d_read_en = 0; d_write_en = 0; end
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
